// File: rtl/mem_io_responder_if.sv
// Byte-wide memory bus between the memory controller and the responder,
// plus the TX/RX byte streams and status flags exposed by the IO window.
interface mem_io_responder_if;
  logic        mem_wr_i;
  logic [31:0] mem_addr_i;
  logic [7:0]  mem_wr_data_i;
  logic [7:0]  mem_din_o;
  logic        io_buffer_full_o;
  logic        tx_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_ready_i;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_full_o;
  logic        program_end_o;
  logic        tx_overflow_o;

  // Responder side.
  modport slave (
    input  mem_wr_i, mem_addr_i, mem_wr_data_i, tx_ready_i, rx_valid_i, rx_data_i,
    output mem_din_o, io_buffer_full_o, tx_valid_o, tx_data_o, rx_full_o,
    output program_end_o, tx_overflow_o
  );

  // Controller / host side.
  modport master (
    output mem_wr_i, mem_addr_i, mem_wr_data_i, tx_ready_i, rx_valid_i, rx_data_i,
    input  mem_din_o, io_buffer_full_o, tx_valid_o, tx_data_o, rx_full_o,
    input  program_end_o, tx_overflow_o
  );
endinterface

// File: rtl/mem_io_responder.sv
// Memory-bus responder: byte RAM with one-cycle read latency, and an IO
// window (addr[17:16] == 2'b11) holding a TX FIFO, an RX FIFO and a sticky
// program-end flag.
module mem_io_responder #(
  parameter int ADDR_WIDTH = 17,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8
) (
  input  logic clk_in,
  input  logic rst_in,
  mem_io_responder_if.slave bus
);

  localparam int TW = $clog2(TX_DEPTH);
  localparam int RW = $clog2(RX_DEPTH);
  localparam logic [TW:0] TX_FULL_CNT = (TW+1)'(TX_DEPTH);
  localparam logic [TW:0] TX_NEAR_CNT = (TW+1)'(TX_DEPTH - 1);
  localparam logic [RW:0] RX_FULL_CNT = (RW+1)'(RX_DEPTH);

  // ---------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------
  logic                  io;
  logic [2:0]            offset;
  logic [ADDR_WIDTH-1:0] ram_idx;
  logic                  unused_addr_bits;

  assign io               = (bus.mem_addr_i[17:16] == 2'b11);
  assign offset           = bus.mem_addr_i[2:0];
  assign ram_idx          = bus.mem_addr_i[ADDR_WIDTH-1:0];
  assign unused_addr_bits = ^bus.mem_addr_i[31:18];

  // ---------------------------------------------------------------------
  // Byte RAM
  // ---------------------------------------------------------------------
  logic [7:0] ram [2**ADDR_WIDTH];

  // RAM write port.
  // NOTE: storage arrays get no reset; a reset branch would turn the RAM
  // into thousands of flops and contents are defined as surviving reset.
  always_ff @(posedge clk_in) begin
    if (bus.mem_wr_i && !io) ram[ram_idx] <= bus.mem_wr_data_i;
  end

  // ---------------------------------------------------------------------
  // TX FIFO (bus -> host)
  // ---------------------------------------------------------------------
  logic [7:0]  tx_mem [TX_DEPTH];
  logic [TW-1:0] tx_rd_ptr, tx_wr_ptr;
  logic [TW:0] tx_count, tx_count_next;
  logic        tx_wr_req, tx_push, tx_pop;

  assign tx_wr_req      = bus.mem_wr_i && io && (offset == 3'd0);
  assign tx_push        = tx_wr_req && (tx_count != TX_FULL_CNT);
  assign bus.tx_valid_o = (tx_count != '0);
  assign tx_pop         = bus.tx_valid_o && bus.tx_ready_i;
  // Gate with valid so the head reads as zero after reset/when empty.
  assign bus.tx_data_o  = bus.tx_valid_o ? tx_mem[tx_rd_ptr] : 8'h00;

  // Next TX occupancy; full/empty guards keep it in range.
  // NOTE: default assigned first so no path leaves the output unassigned
  // (which would infer a latch).
  always_comb begin
    tx_count_next = tx_count;
    case ({tx_push, tx_pop})
      2'b10:   tx_count_next = tx_count + (TW+1)'(1);
      2'b01:   tx_count_next = tx_count - (TW+1)'(1);
      default: tx_count_next = tx_count;
    endcase
  end

  // TX pointers, occupancy, near-full and overflow flags.
  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_rd_ptr            <= '0;
      tx_wr_ptr            <= '0;
      tx_count             <= '0;
      bus.io_buffer_full_o <= 1'b0;
      bus.tx_overflow_o    <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TW'(1);
      tx_count             <= tx_count_next;
      // One slot of headroom for a write the controller already committed.
      bus.io_buffer_full_o <= (tx_count_next >= TX_NEAR_CNT);
      if (tx_wr_req && !tx_push) bus.tx_overflow_o <= 1'b1;
    end
  end

  // TX storage write.
  always_ff @(posedge clk_in) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.mem_wr_data_i;
  end

  // ---------------------------------------------------------------------
  // RX FIFO (host -> bus)
  // ---------------------------------------------------------------------
  logic [7:0]  rx_mem [RX_DEPTH];
  logic [RW-1:0] rx_rd_ptr, rx_wr_ptr;
  logic [RW:0] rx_count;
  logic        rx_push, rx_pop;

  assign bus.rx_full_o = (rx_count == RX_FULL_CNT);
  // A full FIFO refuses the host even if a pop happens the same cycle.
  assign rx_push = bus.rx_valid_i && !bus.rx_full_o;
  assign rx_pop  = !bus.mem_wr_i && io && (offset == 3'd0) && (rx_count != '0);

  // RX pointers and occupancy.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_rd_ptr <= '0;
      rx_wr_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + RW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + RW'(1);
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + (RW+1)'(1);
        2'b01:   rx_count <= rx_count - (RW+1)'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // RX storage write.
  always_ff @(posedge clk_in) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.rx_data_i;
  end

  // ---------------------------------------------------------------------
  // Read data return and program-end flag
  // ---------------------------------------------------------------------
  // Read data: RAM byte, RX head, or zero for writes and other IO offsets.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.mem_din_o <= 8'h00;
    end else if (!bus.mem_wr_i && !io) begin
      bus.mem_din_o <= ram[ram_idx];
    end else if (rx_pop) begin
      bus.mem_din_o <= rx_mem[rx_rd_ptr];
    end else begin
      bus.mem_din_o <= 8'h00;
    end
  end

  // Sticky program-end flag, set by an IO write at offset 4.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.program_end_o <= 1'b0;
    end else if (bus.mem_wr_i && io && (offset == 3'd4)) begin
      bus.program_end_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder with TX_DEPTH=4, RX_DEPTH=2.
module tb_mem_io_responder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_io_responder_if bus_if ();

  mem_io_responder #(
    .ADDR_WIDTH(17),
    .TX_DEPTH  (4),
    .RX_DEPTH  (2)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus   (bus_if)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  din;
    logic        full;
    logic        txv;
    logic [7:0]  txd;
    logic        rxf;
    logic        pend;
    logic        ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, input logic [31:0] addr, input logic [7:0] wdata,
                     input logic rdy, input logic rxv, input logic [7:0] rxd,
                     input logic [7:0] din, input logic full, input logic txv,
                     input logic [7:0] txd, input logic rxf, input logic pend,
                     input logic ovf);
    vec_t v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.tx_ready = rdy;
    v.rx_valid = rxv; v.rx_data = rxd; v.din = din; v.full = full;
    v.txv = txv; v.txd = txd; v.rxf = rxf; v.pend = pend; v.ovf = ovf;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic wr, input logic [31:0] addr, input logic [7:0] wdata,
                       input logic rdy, input logic rxv, input logic [7:0] rxd);
    bus_if.mem_wr_i      = wr;
    bus_if.mem_addr_i    = addr;
    bus_if.mem_wr_data_i = wdata;
    bus_if.tx_ready_i    = rdy;
    bus_if.rx_valid_i    = rxv;
    bus_if.rx_data_i     = rxd;
  endtask

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] din, input logic full,
                           input logic txv, input logic [7:0] txd, input logic rxf,
                           input logic pend, input logic ovf);
    check({tag, " din"},  32'(bus_if.mem_din_o),        32'(din));
    check({tag, " full"}, 32'(bus_if.io_buffer_full_o), 32'(full));
    check({tag, " txv"},  32'(bus_if.tx_valid_o),       32'(txv));
    check({tag, " txd"},  32'(bus_if.tx_data_o),        32'(txd));
    check({tag, " rxf"},  32'(bus_if.rx_full_o),        32'(rxf));
    check({tag, " pend"}, 32'(bus_if.program_end_o),    32'(pend));
    check({tag, " ovf"},  32'(bus_if.tx_overflow_o),    32'(ovf));
  endtask

  localparam logic [31:0] TXA = 32'h0003_0000;
  localparam logic [31:0] PEA = 32'h0003_0004;

  initial begin
    drive(1'b0, PEA, 8'h00, 1'b0, 1'b0, 8'h00);

    // wr addr wdata rdy rxv rxd | din full txv txd rxf pend ovf
    // RAM writes then streamed reads
    add(1, 32'h100, 8'h11, 0, 0, 8'h00,  8'h00, 0, 0, 8'h00, 0, 0, 0);
    add(1, 32'h101, 8'h22, 0, 0, 8'h00,  8'h00, 0, 0, 8'h00, 0, 0, 0);
    add(1, 32'h102, 8'h33, 0, 0, 8'h00,  8'h00, 0, 0, 8'h00, 0, 0, 0);
    add(1, 32'h103, 8'h44, 0, 0, 8'h00,  8'h00, 0, 0, 8'h00, 0, 0, 0);
    add(0, 32'h100, 8'h00, 0, 0, 8'h00,  8'h11, 0, 0, 8'h00, 0, 0, 0);
    add(0, 32'h101, 8'h00, 0, 0, 8'h00,  8'h22, 0, 0, 8'h00, 0, 0, 0);
    add(0, 32'h102, 8'h00, 0, 0, 8'h00,  8'h33, 0, 0, 8'h00, 0, 0, 0);
    add(0, 32'h103, 8'h00, 0, 0, 8'h00,  8'h44, 0, 0, 8'h00, 0, 0, 0);
    // Upper address bits ignored; bit 17 alone wraps the RAM
    add(0, 32'hFFFC_0100, 8'h00, 0, 0, 8'h00, 8'h11, 0, 0, 8'h00, 0, 0, 0);
    add(0, 32'h0002_0101, 8'h00, 0, 0, 8'h00, 8'h22, 0, 0, 8'h00, 0, 0, 0);
    // TX fill to near-full, full, then overflow
    add(1, TXA, 8'h41, 0, 0, 8'h00,  8'h00, 0, 1, 8'h41, 0, 0, 0);
    add(1, TXA, 8'h42, 0, 0, 8'h00,  8'h00, 0, 1, 8'h41, 0, 0, 0);
    add(1, TXA, 8'h43, 0, 0, 8'h00,  8'h00, 1, 1, 8'h41, 0, 0, 0);
    add(1, TXA, 8'h44, 0, 0, 8'h00,  8'h00, 1, 1, 8'h41, 0, 0, 0);
    add(1, TXA, 8'h45, 0, 0, 8'h00,  8'h00, 1, 1, 8'h41, 0, 0, 1);
    // TX drain
    add(0, PEA, 8'h00, 1, 0, 8'h00,  8'h00, 1, 1, 8'h42, 0, 0, 1);
    add(0, PEA, 8'h00, 1, 0, 8'h00,  8'h00, 0, 1, 8'h43, 0, 0, 1);
    add(0, PEA, 8'h00, 1, 0, 8'h00,  8'h00, 0, 1, 8'h44, 0, 0, 1);
    add(0, PEA, 8'h00, 1, 0, 8'h00,  8'h00, 0, 0, 8'h00, 0, 0, 1);
    // RX fill, push while full ignored
    add(0, PEA, 8'h00, 0, 1, 8'h0A,  8'h00, 0, 0, 8'h00, 0, 0, 1);
    add(0, PEA, 8'h00, 0, 1, 8'h0B,  8'h00, 0, 0, 8'h00, 1, 0, 1);
    add(0, PEA, 8'h00, 0, 1, 8'h0C,  8'h00, 0, 0, 8'h00, 1, 0, 1);
    // RX drain, then empty read
    add(0, TXA, 8'h00, 0, 0, 8'h00,  8'h0A, 0, 0, 8'h00, 0, 0, 1);
    add(0, TXA, 8'h00, 0, 0, 8'h00,  8'h0B, 0, 0, 8'h00, 0, 0, 1);
    add(0, TXA, 8'h00, 0, 0, 8'h00,  8'h00, 0, 0, 8'h00, 0, 0, 1);
    // Program end, read back of 0x30004, write to an unused offset
    add(1, PEA, 8'h01, 0, 0, 8'h00,  8'h00, 0, 0, 8'h00, 0, 1, 1);
    add(0, PEA, 8'h00, 0, 0, 8'h00,  8'h00, 0, 0, 8'h00, 0, 1, 1);
    add(1, 32'h0003_0001, 8'h99, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 1, 1);
    // RX simultaneous push and pop
    add(0, PEA, 8'h00, 0, 1, 8'h0D,  8'h00, 0, 0, 8'h00, 0, 1, 1);
    add(0, TXA, 8'h00, 0, 1, 8'h0E,  8'h0D, 0, 0, 8'h00, 0, 1, 1);
    add(0, TXA, 8'h00, 0, 0, 8'h00,  8'h0E, 0, 0, 8'h00, 0, 1, 1);
    // RX full: same-cycle pop does not admit the push
    add(0, PEA, 8'h00, 0, 1, 8'h21,  8'h00, 0, 0, 8'h00, 0, 1, 1);
    add(0, PEA, 8'h00, 0, 1, 8'h22,  8'h00, 0, 0, 8'h00, 1, 1, 1);
    add(0, TXA, 8'h00, 0, 1, 8'h23,  8'h21, 0, 0, 8'h00, 0, 1, 1);
    add(0, TXA, 8'h00, 0, 0, 8'h00,  8'h22, 0, 0, 8'h00, 0, 1, 1);
    add(0, TXA, 8'h00, 0, 0, 8'h00,  8'h00, 0, 0, 8'h00, 0, 1, 1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", 8'h00, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].wr, vecs[i].addr, vecs[i].wdata,
            vecs[i].tx_ready, vecs[i].rx_valid, vecs[i].rx_data);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].din, vecs[i].full, vecs[i].txv,
                vecs[i].txd, vecs[i].rxf, vecs[i].pend, vecs[i].ovf);
    end

    // Read-after-write on consecutive cycles
    drive(1, 32'h200, 8'h5A, 0, 0, 8'h00);
    step();
    drive(0, 32'h200, 8'h00, 0, 0, 8'h00);
    step();
    check("raw din", 32'(bus_if.mem_din_o), 32'h5A);

    // Simultaneous TX push and pop with two entries queued
    drive(1, TXA, 8'h61, 0, 0, 8'h00);
    step();
    drive(1, TXA, 8'h62, 0, 0, 8'h00);
    step();
    drive(1, TXA, 8'h55, 1, 0, 8'h00);
    step();
    check("simtx head", 32'(bus_if.tx_data_o), 32'h62);
    check("simtx full", 32'(bus_if.io_buffer_full_o), 32'h0);
    drive(0, PEA, 8'h00, 1, 0, 8'h00);
    step();
    check("simtx last", 32'(bus_if.tx_data_o), 32'h55);
    check("simtx last v", 32'(bus_if.tx_valid_o), 32'h1);
    step();
    check("simtx empty", 32'(bus_if.tx_valid_o), 32'h0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      drive(1, TXA, 8'(8'h71 + i), 0, 0, 8'h00);
      step();
    end
    drive(0, 32'h100, 8'h00, 0, 0, 8'h00);
    step();
    check_all("prerst", 8'h11, 1, 1, 8'h71, 0, 1, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("asyncrst", 8'h00, 0, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("postrst ram", 32'(bus_if.mem_din_o), 32'h11);
    check("postrst txv", 32'(bus_if.tx_valid_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
